// File: rtl/enigma_buffer_mp.sv
// Shared multi-port request buffer: NUM_PORTS writers, one QoS/aging-arbitrated
// output with per-ID ordering and conflict/release retry.
module enigma_buffer_mp #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_W     = 128,
    parameter int ID_W       = 5,
    parameter int QOS_W      = 2,
    parameter int DEPTH      = 16,
    parameter int AGE_THRESH = 8,
    parameter int PORT_W     = $clog2(NUM_PORTS),
    parameter int OID_W      = ID_W + PORT_W,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS*DATA_W-1:0] payload_i,
    input  logic [NUM_PORTS*ID_W-1:0]   id_i,
    input  logic [NUM_PORTS*QOS_W-1:0]  qos_i,
    input  logic [NUM_PORTS-1:0]        valid_i,
    output logic [NUM_PORTS-1:0]        ready_i,
    output logic                        valid_c,
    input  logic                        ready_c,
    output logic [DATA_W-1:0]           payload_c,
    output logic [OID_W-1:0]            id_c,
    output logic [QOS_W-1:0]            qos_c,
    input  logic                        conflict_c,
    input  logic                        release_c,
    input  logic [OID_W-1:0]            releaseid_c,
    output logic [CNT_W-1:0]            occupancy,
    output logic [CNT_W-1:0]            blocked_cnt
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int AGE_W = (AGE_THRESH < 1) ? 1 : $clog2(AGE_THRESH + 1);

    logic [DEPTH-1:0]  vld_q, blk_q, dep_v_q, tail_q;
    logic [DEPTH-1:0]  vld_d, blk_d, dep_v_d, tail_d;
    logic [IDX_W-1:0]  dep_idx_q [DEPTH];
    logic [IDX_W-1:0]  dep_idx_d [DEPTH];
    logic [OID_W-1:0]  oid_q [DEPTH];
    logic [OID_W-1:0]  oid_d [DEPTH];
    logic [QOS_W-1:0]  qos_q [DEPTH];
    logic [QOS_W-1:0]  qos_d [DEPTH];
    logic [AGE_W-1:0]  age_q [DEPTH];
    logic [AGE_W-1:0]  age_d [DEPTH];
    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  sel_ptr;
    logic              valid_q;
    logic [CNT_W-1:0]  free_cnt, occ_d, blk_cnt_d;
    logic [NUM_PORTS-1:0] acc;
    logic [IDX_W-1:0]  alloc_idx [NUM_PORTS];
    logic [DEPTH-1:0]  elig;
    logic [IDX_W-1:0]  best_idx;
    logic              any_elig;
    logic              hs, load, free_en;

    assign hs       = valid_q & ready_c;
    assign load     = ~valid_q | hs;
    assign free_en  = hs & ~conflict_c;
    assign free_cnt = CNT_W'(DEPTH) - occupancy;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++)
            ready_i[p] = (free_cnt > CNT_W'(p));
    end

    // Lower ports claim lower free slots; slots freed this cycle are not visible yet.
    always_comb begin : alloc_blk
        logic             found;
        logic [DEPTH-1:0] taken;
        taken = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            acc[p]       = valid_i[p] & ready_i[p];
            alloc_idx[p] = '0;
            found        = 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                if (acc[p] && !found && !vld_q[k] && !taken[k]) begin
                    alloc_idx[p] = IDX_W'(k);
                    found        = 1'b1;
                end
            end
            if (acc[p])
                taken[alloc_idx[p]] = 1'b1;
        end
    end

    always_comb begin : select_blk
        logic [QOS_W-1:0] eff, best_eff;
        logic [AGE_W-1:0] best_age;
        best_idx = '0;
        any_elig = 1'b0;
        best_eff = '0;
        best_age = '0;
        for (int k = 0; k < DEPTH; k++) begin
            elig[k] = vld_q[k] & ~blk_q[k] & ~dep_v_q[k] & ~(valid_q && sel_ptr == IDX_W'(k));
            eff     = (age_q[k] >= AGE_W'(AGE_THRESH)) ? {QOS_W{1'b1}} : qos_q[k];
            if (elig[k] && (!any_elig || eff > best_eff ||
                            (eff == best_eff && age_q[k] > best_age))) begin
                best_idx = IDX_W'(k);
                best_eff = eff;
                best_age = age_q[k];
                any_elig = 1'b1;
            end
        end
    end

    always_comb begin : next_blk
        logic [OID_W-1:0] oid_new;
        logic [IDX_W-1:0] a;
        vld_d  = vld_q;
        blk_d  = blk_q;
        dep_v_d = dep_v_q;
        tail_d = tail_q;
        oid_new = '0;
        a       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            dep_idx_d[k] = dep_idx_q[k];
            oid_d[k]     = oid_q[k];
            qos_d[k]     = qos_q[k];
            age_d[k]     = age_q[k];
            if (elig[k] && !(load && best_idx == IDX_W'(k)) && !(&age_q[k]))
                age_d[k] = age_q[k] + AGE_W'(1);
            if (free_en && dep_v_q[k] && dep_idx_q[k] == sel_ptr)
                dep_v_d[k] = 1'b0;
            if (release_c && blk_q[k] && oid_q[k] == releaseid_c) begin
                blk_d[k] = 1'b0;
                age_d[k] = '0;
            end
        end
        if (free_en) begin
            vld_d[sel_ptr]  = 1'b0;
            tail_d[sel_ptr] = 1'b0;
        end
        if (hs && conflict_c) begin
            blk_d[sel_ptr] = 1'b1;
            age_d[sel_ptr] = '0;
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (acc[p]) begin
                oid_new      = {PORT_W'(p), id_i[p*ID_W +: ID_W]};
                a            = alloc_idx[p];
                vld_d[a]     = 1'b1;
                blk_d[a]     = 1'b0;
                tail_d[a]    = 1'b1;
                age_d[a]     = '0;
                oid_d[a]     = oid_new;
                qos_d[a]     = qos_i[p*QOS_W +: QOS_W];
                dep_v_d[a]   = 1'b0;
                dep_idx_d[a] = '0;
                // Link behind the current chain tail unless that tail leaves at this edge.
                for (int j = 0; j < DEPTH; j++) begin
                    if (vld_q[j] && tail_q[j] && oid_q[j] == oid_new) begin
                        tail_d[j]    = 1'b0;
                        dep_idx_d[a] = IDX_W'(j);
                        dep_v_d[a]   = !(free_en && sel_ptr == IDX_W'(j));
                    end
                end
            end
        end
        occ_d     = '0;
        blk_cnt_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_d     = occ_d + CNT_W'(vld_d[k]);
            blk_cnt_d = blk_cnt_d + CNT_W'(vld_d[k] & blk_d[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            blk_q       <= '0;
            dep_v_q     <= '0;
            tail_q      <= '0;
            sel_ptr     <= '0;
            valid_q     <= 1'b0;
            occupancy   <= '0;
            blocked_cnt <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dep_idx_q[k] <= '0;
                oid_q[k]     <= '0;
                qos_q[k]     <= '0;
                age_q[k]     <= '0;
            end
        end else begin
            vld_q       <= vld_d;
            blk_q       <= blk_d;
            dep_v_q     <= dep_v_d;
            tail_q      <= tail_d;
            occupancy   <= occ_d;
            blocked_cnt <= blk_cnt_d;
            for (int k = 0; k < DEPTH; k++) begin
                dep_idx_q[k] <= dep_idx_d[k];
                oid_q[k]     <= oid_d[k];
                qos_q[k]     <= qos_d[k];
                age_q[k]     <= age_d[k];
            end
            if (load) begin
                sel_ptr <= best_idx;
                valid_q <= any_elig;
            end
        end
    end

    // Payload storage needs no reset: it is only observed through a valid entry.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++)
            if (acc[p])
                mem[alloc_idx[p]] <= payload_i[p*DATA_W +: DATA_W];
    end

    assign valid_c   = valid_q;
    assign payload_c = valid_q ? mem[sel_ptr]   : '0;
    assign id_c      = valid_q ? oid_q[sel_ptr] : '0;
    assign qos_c     = valid_q ? qos_q[sel_ptr] : '0;

endmodule

// File: tb/tb_enigma_buffer_mp.sv
// Randomized bench for enigma_buffer_mp against a slot-level behavioural model
// that derives ordering from arrival sequence numbers.
module tb_enigma_buffer_mp;
    localparam int NP = 2, DW = 128, IW = 5, QW = 2, D = 16, AT = 8, OW = 6, CW = 5;
    localparam int AGE_SAT = 15;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [NP*DW-1:0] payload_i = '0;
    logic [NP*IW-1:0] id_i = '0;
    logic [NP*QW-1:0] qos_i = '0;
    logic [NP-1:0]    valid_i = '0;
    logic [NP-1:0]    ready_i;
    logic             valid_c;
    logic             ready_c = 1'b0;
    logic [DW-1:0]    payload_c;
    logic [OW-1:0]    id_c;
    logic [QW-1:0]    qos_c;
    logic             conflict_c = 1'b0, release_c = 1'b0;
    logic [OW-1:0]    releaseid_c = '0;
    logic [CW-1:0]    occupancy, blocked_cnt;

    enigma_buffer_mp #(.NUM_PORTS(NP), .DATA_W(DW), .ID_W(IW), .QOS_W(QW),
                       .DEPTH(D), .AGE_THRESH(AT)) dut (
        .clk(clk), .rst_n(rst_n), .payload_i(payload_i), .id_i(id_i), .qos_i(qos_i),
        .valid_i(valid_i), .ready_i(ready_i), .valid_c(valid_c), .ready_c(ready_c),
        .payload_c(payload_c), .id_c(id_c), .qos_c(qos_c), .conflict_c(conflict_c),
        .release_c(release_c), .releaseid_c(releaseid_c), .occupancy(occupancy),
        .blocked_cnt(blocked_cnt));

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference state: one record per slot, ordering by arrival sequence.
    bit            m_v [D];
    bit            m_b [D];
    logic [OW-1:0] m_id [D];
    logic [QW-1:0] m_q [D];
    logic [DW-1:0] m_pay [D];
    int            m_age [D];
    int            m_seq [D];
    int            m_sel;
    bit            m_valid;
    int            seq_ctr;

    task automatic model_reset();
        for (int k = 0; k < D; k++) begin
            m_v[k] = 0; m_b[k] = 0; m_id[k] = '0; m_q[k] = '0;
            m_pay[k] = '0; m_age[k] = 0; m_seq[k] = 0;
        end
        m_sel = 0; m_valid = 0; seq_ctr = 0;
    endtask

    function automatic bit has_older(input int k);
        for (int j = 0; j < D; j++)
            if (j != k && m_v[j] && m_id[j] == m_id[k] && m_seq[j] < m_seq[k]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int count_valid();
        int c = 0;
        for (int k = 0; k < D; k++) c += int'(m_v[k]);
        return c;
    endfunction

    task automatic model_step();
        bit elig [D];
        bit rdy [NP];
        bit hs, load, any;
        int best, be, ba, eff, cnt;
        cnt  = count_valid();
        for (int p = 0; p < NP; p++) rdy[p] = (D - cnt) > p;
        hs   = m_valid && ready_c;
        load = !m_valid || hs;
        any = 0; best = 0; be = -1; ba = -1;
        for (int k = 0; k < D; k++) begin
            elig[k] = m_v[k] && !m_b[k] && !(m_valid && k == m_sel) && !has_older(k);
            if (elig[k]) begin
                eff = (m_age[k] >= AT) ? 3 : int'(m_q[k]);
                if (eff > be || (eff == be && m_age[k] > ba)) begin
                    best = k; be = eff; ba = m_age[k]; any = 1;
                end
            end
        end
        for (int k = 0; k < D; k++)
            if (elig[k] && !(load && k == best) && m_age[k] < AGE_SAT) m_age[k]++;
        if (release_c)
            for (int k = 0; k < D; k++)
                if (m_v[k] && m_b[k] && m_id[k] == releaseid_c) begin
                    m_b[k] = 0; m_age[k] = 0;
                end
        for (int p = 0; p < NP; p++) begin
            if (valid_i[p] && rdy[p]) begin
                for (int k = 0; k < D; k++) begin
                    if (!m_v[k]) begin
                        m_v[k] = 1; m_b[k] = 0; m_age[k] = 0; m_seq[k] = seq_ctr++;
                        m_id[k]  = {1'(p), id_i[p*IW +: IW]};
                        m_q[k]   = qos_i[p*QW +: QW];
                        m_pay[k] = payload_i[p*DW +: DW];
                        break;
                    end
                end
            end
        end
        if (hs) begin
            if (conflict_c) begin
                m_b[m_sel] = 1; m_age[m_sel] = 0;
            end else
                m_v[m_sel] = 0;
        end
        if (load) begin
            m_sel = best; m_valid = any;
        end
    endtask

    task automatic compare_all();
        logic [NP-1:0] er;
        int cnt, bc;
        cnt = count_valid();
        bc  = 0;
        for (int k = 0; k < D; k++) bc += int'(m_v[k] && m_b[k]);
        for (int p = 0; p < NP; p++) er[p] = (D - cnt) > p;
        chk("ready_i", 128'(ready_i), 128'(er));
        chk("valid_c", 128'(valid_c), 128'(m_valid));
        chk("id_c", 128'(id_c), m_valid ? 128'(m_id[m_sel]) : 128'(0));
        chk("qos_c", 128'(qos_c), m_valid ? 128'(m_q[m_sel]) : 128'(0));
        chk("payload_c", payload_c, m_valid ? m_pay[m_sel] : 128'(0));
        chk("occupancy", 128'(occupancy), 128'(cnt));
        chk("blocked_cnt", 128'(blocked_cnt), 128'(bc));
    endtask

    task automatic drive_idle();
        valid_i = '0; ready_c = 1'b0; conflict_c = 1'b0; release_c = 1'b0;
    endtask

    function automatic logic [OW-1:0] pick_release();
        int off = $urandom_range(0, D-1);
        for (int i = 0; i < D; i++) begin
            int k = (off + i) % D;
            if (m_v[k] && m_b[k]) return m_id[k];
        end
        return OW'($urandom_range(0, 3));
    endfunction

    // ph 0 mixed, 1 fill/stall, 2 id-collision + retry, 3 aging, 4 drain
    task automatic drive(input int ph);
        int pv, pr, pc, pl, idmax;
        case (ph)
            0: begin pv = 40; pr = 70;  pc = 15; pl = 25;  idmax = 3; end
            1: begin pv = 90; pr = 0;   pc = 0;  pl = 0;   idmax = 3; end
            2: begin pv = 50; pr = 60;  pc = 35; pl = 30;  idmax = 1; end
            3: begin pv = 15; pr = 100; pc = 0;  pl = 20;  idmax = 3; end
            default: begin pv = 0; pr = 100; pc = 0; pl = 100; idmax = 3; end
        endcase
        for (int p = 0; p < NP; p++) begin
            valid_i[p] = ($urandom_range(0, 99) < pv);
            id_i[p*IW +: IW]  = IW'($urandom_range(0, idmax));
            qos_i[p*QW +: QW] = QW'($urandom_range(0, 3));
            payload_i[p*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
        end
        if (ph == 3) begin
            valid_i[1] = 1'b1;
            qos_i[QW +: QW] = 2'd3;
            qos_i[0 +: QW]  = 2'd0;
        end
        ready_c    = ($urandom_range(0, 99) < pr);
        conflict_c = ($urandom_range(0, 99) < pc);
        release_c  = ($urandom_range(0, 99) < pl);
        releaseid_c = $urandom_range(0, 1) ? pick_release() : OW'($urandom_range(0, 33));
    endtask

    task automatic run(input int ph, input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            compare_all();
            drive(ph);
            model_step();
        end
    endtask

    task automatic do_reset_release();
        @(negedge clk);
        rst_n = 1'b1;
        drive_idle();
        model_step();
    endtask

    initial begin
        model_reset();
        drive_idle();
        #1;
        compare_all();
        do_reset_release();
        run(0, 300);
        run(1, 40);
        run(0, 200);
        run(2, 400);
        run(3, 300);
        run(4, 120);
        @(negedge clk);
        compare_all();
        chk("drained_occupancy", 128'(occupancy), 128'(0));
        drive(1);
        model_step();
        run(1, 30);
        // Asynchronous reset between edges with the buffer loaded.
        @(negedge clk);
        compare_all();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        do_reset_release();
        run(2, 300);
        run(3, 200);
        run(4, 120);
        @(negedge clk);
        compare_all();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
